// File: rtl/ft245_bus_ctrl_pkg.sv
// Shared definitions for the FT245 bus controller: FSM state encoding, arbitration
// grant encoding, default strobe/recovery timings and the width of the shared
// state-timing down-counter.
package ft245_pkg;

  localparam int unsigned CntW = 4;

  localparam int unsigned DefRdCycles      = 3;
  localparam int unsigned DefWrSetupCycles = 1;
  localparam int unsigned DefWrCycles      = 3;
  localparam int unsigned DefRecoverCycles = 4;

  typedef enum logic [2:0] {
    StIdle,
    StRdStrobe,
    StWrSetup,
    StWrStrobe,
    StWrHold,
    StRecover
  } state_e;

  typedef enum logic {
    GrantRx = 1'b0,
    GrantTx = 1'b1
  } grant_e;

  // A state lasting N cycles loads N-1 and leaves when the counter reads zero.
  function automatic logic [CntW-1:0] cnt_load(input int unsigned cycles);
    return CntW'(cycles - 1);
  endfunction

endpackage

// File: rtl/ft245_bus_ctrl_if.sv
// Signal bundle between the FT245 bus controller and its surroundings.
//   Chip side : rxf_n, txe_n (synchronized flags), bus_di/bus_do/bus_oe, bus_rd/bus_wr
//   SoC TX    : tx_data, tx_valid, tx_ready
//   SoC RX    : rx_data, rx_valid, rx_ready
// master = the controller's view; slave = the view of the pads and the SoC.
interface ft245_bus_ctrl_if;

  logic       rxf_n;
  logic       txe_n;
  logic [7:0] bus_di;
  logic [7:0] bus_do;
  logic       bus_oe;
  logic       bus_rd;
  logic       bus_wr;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (
    input  rxf_n, txe_n, bus_di, tx_data, tx_valid, rx_ready,
    output bus_do, bus_oe, bus_rd, bus_wr, tx_ready, rx_data, rx_valid
  );

  modport slave (
    output rxf_n, txe_n, bus_di, tx_data, tx_valid, rx_ready,
    input  bus_do, bus_oe, bus_rd, bus_wr, tx_ready, rx_data, rx_valid
  );

endinterface

// File: rtl/ft245_bus_ctrl.sv
// FT245-style parallel FIFO bus sequencer. Owns the shared data bus and RD/WR strobes,
// alternates between draining host-to-device bytes and pushing device-to-host bytes,
// and presents each direction to the SoC as a valid/ready byte stream.
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   io_bus : master modport of ft245_bus_ctrl_if (chip flags/bus, TX and RX streams)
// All outputs are registered except tx_ready.
module ft245_bus_ctrl
  import ft245_pkg::*;
#(
  parameter int unsigned RD_CYCLES       = DefRdCycles,
  parameter int unsigned WR_SETUP_CYCLES = DefWrSetupCycles,
  parameter int unsigned WR_CYCLES       = DefWrCycles,
  parameter int unsigned RECOVER_CYCLES  = DefRecoverCycles
) (
  input  logic              clk,
  input  logic              rst_n,
  ft245_bus_ctrl_if.master  io_bus
);

  localparam logic [CntW-1:0] RdLoad      = cnt_load(RD_CYCLES);
  localparam logic [CntW-1:0] WrSetupLoad = cnt_load(WR_SETUP_CYCLES);
  localparam logic [CntW-1:0] WrLoad      = cnt_load(WR_CYCLES);
  localparam logic [CntW-1:0] RecoverLoad = cnt_load(RECOVER_CYCLES);

  state_e          r_state, w_state_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  grant_e          r_last_grant;
  logic [7:0]      r_tx_data;
  logic [7:0]      r_rx_data;
  logic            r_rx_valid;
  logic            r_bus_rd;
  logic            r_bus_wr;
  logic            r_bus_oe;

  logic w_idle;
  logic w_rx_elig;
  logic w_tx_ready;
  logic w_tx_accept;
  logic w_rx_grant;
  logic w_cnt_done;
  logic w_rd_capture;

  // Arbitration, only meaningful in IDLE. RX is blocked while the 1-entry buffer is
  // full, so a read can never overrun it. On a tie the direction not served last wins.
  always_comb begin
    w_idle      = (r_state == StIdle);
    w_rx_elig   = !io_bus.rxf_n && !r_rx_valid;
    // rst_n gating keeps tx_ready low while reset is held, even though state is IDLE.
    w_tx_ready  = rst_n && w_idle && !io_bus.txe_n && !(w_rx_elig && (r_last_grant == GrantTx));
    w_tx_accept = w_tx_ready && io_bus.tx_valid;
    w_rx_grant  = w_idle && w_rx_elig && !w_tx_accept;
    w_cnt_done  = (r_cnt == '0);
  end

  always_comb begin
    w_state_d    = r_state;
    w_cnt_d      = w_cnt_done ? '0 : r_cnt - 1'b1;
    w_rd_capture = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_rx_grant) begin
          w_state_d = StRdStrobe;
          w_cnt_d   = RdLoad;
        end else if (w_tx_accept) begin
          w_state_d = StWrSetup;
          w_cnt_d   = WrSetupLoad;
        end
      end
      StRdStrobe: begin
        if (w_cnt_done) begin
          w_rd_capture = 1'b1;
          w_state_d    = StRecover;
          w_cnt_d      = RecoverLoad;
        end
      end
      StWrSetup: begin
        if (w_cnt_done) begin
          w_state_d = StWrStrobe;
          w_cnt_d   = WrLoad;
        end
      end
      StWrStrobe: begin
        if (w_cnt_done) begin
          w_state_d = StWrHold;
          w_cnt_d   = '0;
        end
      end
      StWrHold: begin
        w_state_d = StRecover;
        w_cnt_d   = RecoverLoad;
      end
      StRecover: begin
        if (w_cnt_done) begin
          w_state_d = StIdle;
        end
      end
      default: begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // Strobes are decoded from the next state so they are flop outputs aligned with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bus_rd <= 1'b0;
      r_bus_wr <= 1'b0;
      r_bus_oe <= 1'b0;
    end else begin
      r_bus_rd <= (w_state_d == StRdStrobe);
      r_bus_wr <= (w_state_d == StWrStrobe);
      r_bus_oe <= (w_state_d inside {StWrSetup, StWrStrobe, StWrHold});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= GrantTx;
      r_tx_data    <= 8'h00;
    end else begin
      if (w_rx_grant) begin
        r_last_grant <= GrantRx;
      end else if (w_tx_accept) begin
        r_last_grant <= GrantTx;
        r_tx_data    <= io_bus.tx_data;
      end
    end
  end

  // RX buffer. Capture and consume never coincide: a read only starts when it is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
    end else if (w_rd_capture) begin
      r_rx_data  <= io_bus.bus_di;
      r_rx_valid <= 1'b1;
    end else if (r_rx_valid && io_bus.rx_ready) begin
      r_rx_valid <= 1'b0;
    end
  end

  assign io_bus.bus_do   = r_tx_data;
  assign io_bus.bus_oe   = r_bus_oe;
  assign io_bus.bus_rd   = r_bus_rd;
  assign io_bus.bus_wr   = r_bus_wr;
  assign io_bus.tx_ready = w_tx_ready;
  assign io_bus.rx_data  = r_rx_data;
  assign io_bus.rx_valid = r_rx_valid;

endmodule

// File: doc/ft245_bus_ctrl.md
# ft245_bus_ctrl

Sequencing controller for the FT245-style parallel USB FIFO bus. It owns the shared 8-bit data bus and the RD/WR strobes, and arbitrates between draining host-to-device bytes (RXF) and pushing device-to-host bytes (TXE). It presents each direction to the SoC as a valid/ready byte stream. The block sits inside the SoC between the already-synchronized bus flags and the pad-level tristate.

## Interface
Parameters:
- RD_CYCLES, 3: cycles `bus_rd` is held high; data is sampled on the last one. Range 1..15.
- WR_SETUP_CYCLES, 1: cycles data is driven before `bus_wr` rises. Range 1..15.
- WR_CYCLES, 3: cycles `bus_wr` is held high. Range 1..15.
- RECOVER_CYCLES, 4: idle cycles after any strobe, covering the 2-flop flag sync plus chip flag update. Range 3..15.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  reset, asynchronous, active-low.
- rxf_n  in  1  synchronized RXF#; low means the chip holds a byte to read.
- txe_n  in  1  synchronized TXE#; low means the chip can accept a byte.
- bus_di  in  8  data bus input.
- bus_do  out  8  data bus output.
- bus_oe  out  1  drive enable for `bus_do`; the top level tristates on this signal, not on `bus_wr`.
- bus_rd  out  1  read strobe, active-high; the top level inverts it.
- bus_wr  out  1  write strobe, active-high; the top level inverts it.
- tx_data  in  8  byte to send.
- tx_valid  in  1  `tx_data` is valid.
- tx_ready  out  1  byte is accepted this cycle if `tx_valid` is high.
- rx_data  out  8  received byte.
- rx_valid  out  1  `rx_data` is valid; held until accepted.
- rx_ready  in  1  consumer accepts `rx_data`.

## Operation
- States: IDLE, RD_STROBE, WR_SETUP, WR_STROBE, WR_HOLD, RECOVER. A single 4-bit down-counter times every state.
- Eligibility is evaluated only in IDLE:
  - rx_elig = !rxf_n && !rx_valid. A read is never issued while the 1-entry RX buffer is full, so no overrun is possible.
  - tx_elig = !txe_n && tx_valid.
- Arbitration when both are eligible: alternate, granting the direction not served last. A `last_grant` flop resets to TX, so RX wins the first tie. A single eligible direction is always granted.
- `tx_ready` = (state==IDLE) && !txe_n && !(rx_elig && last_grant==TX). It must not depend on `tx_valid`. Accepting a byte latches `tx_data` into the write register and moves to WR_SETUP.
- Read path: IDLE to RD_STROBE (`bus_rd`=1 for RD_CYCLES). On the final cycle's edge, `bus_di` is captured into `rx_data`, `rx_valid` is set, and the state moves to RECOVER.
- Write path:
  - WR_SETUP: `bus_oe`=1, `bus_wr`=0, for WR_SETUP_CYCLES.
  - WR_STROBE: `bus_oe`=1, `bus_wr`=1, for WR_CYCLES.
  - WR_HOLD: `bus_oe`=1, `bus_wr`=0, for 1 cycle.
  - Then RECOVER.
- RECOVER: all strobes and `bus_oe` are low for RECOVER_CYCLES, then the state returns to IDLE.
- `rx_valid` clears on `rx_valid && rx_ready`. This is independent of the state machine and may coincide with any state.
- `bus_rd` and `bus_oe` are never high in the same cycle. `bus_rd` and `bus_wr` are never high together.
- If `rxf_n` or `txe_n` deasserts mid-transaction, the transaction still completes; the flags are only sampled in IDLE.

## Timing
- Reset values: state IDLE, all strobes 0, `bus_oe` 0, `bus_do` 0x00, `rx_data` 0x00, `rx_valid` 0, `tx_ready` 0 (no combinational assertion while `rst_n` is low), `last_grant` TX.
- Reset assertion mid-operation drops strobes and `bus_oe` asynchronously. An accepted but unsent TX byte is discarded, and any buffered RX byte is lost.
- All outputs except `tx_ready` are registered.
- Read cost: 1 (IDLE) + RD_CYCLES + RECOVER_CYCLES = 8 cycles at defaults. `rx_valid` rises the cycle after the last `bus_rd` cycle.
- Write cost: 1 + WR_SETUP_CYCLES + WR_CYCLES + 1 + RECOVER_CYCLES = 10 cycles at defaults.
- Back-to-back transactions have no gap beyond RECOVER plus the single IDLE decision cycle.

## Structure
- `ft245_pkg`: state enum, default cycle constants, and the counter width (4).
- No sub-module: arbiter, counter and RX buffer stay inline.
- The top level connects `bus_oe` to the pad tristate enable.

## Test plan
- Single read: `rxf_n`=0, `bus_di`=0xA5.
  - `bus_rd` high for exactly cycles 1..3 after IDLE.
  - `rx_valid`=1 with `rx_data`=0xA5 at cycle 4.
  - Next IDLE at cycle 8.
- Single write: `txe_n`=0, `tx_valid`=1, `tx_data`=0x3C.
  - `tx_ready` for 1 cycle.
  - `bus_oe` high for 5 cycles with `bus_do`=0x3C.
  - `bus_wr` high only in cycles 2..4 of that window.
- Tie arbitration: both eligible continuously with `rx_ready`=1 → grant order is RX, TX, RX, TX.
- Backpressure: `rxf_n`=0, `rx_ready`=0 → exactly one read. `bus_rd` then stays low indefinitely, and TX traffic still proceeds.
- Flag drop: `txe_n` rises during WR_STROBE → the write completes. No new write starts until `txe_n` returns low.
- Async reset during WR_STROBE → `bus_wr` and `bus_oe` fall within the same cycle. All outputs match the reset values, and the first post-reset tie goes to RX.
